// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM states, error codes and default SoC memory map for the bus fabric
package mem_bus_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_RO_WRITE = 2'd3
    } err_t;
    localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE    = 32'h1000_0000;
    localparam logic [31:0] UART_BASE   = 32'h8000_0000;
    localparam logic [31:0] LED_BASE    = 32'h9000_0000;
    localparam logic [31:0] REGION_MASK = 32'hFFFF_0000;
endpackage

// File: rtl/mem_bus_addr_match.sv
// mem_bus_addr_match: per-slave base/mask decode with lowest-index priority
//   addr in  : request address
//   hit  out : some region matches
//   sel  out : index of the lowest-numbered matching slave (0 when no hit)
module mem_bus_addr_match #(
    parameter int N_SLAVES = 4,
    parameter int SW = 2,
    parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = '0,
    parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = '0
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [SW-1:0] sel
);
    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit = 1'b1;
                sel = SW'(i);
            end
        end
    end
endmodule

// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: N-slave picorv32 native-bus interconnect with wait states and error side-channel
//   clk, rst                       : clock, synchronous active-high reset
//   m_valid/m_ready/m_addr/m_wdata/m_wstrb/m_rdata : CPU side (m_ready, m_rdata registered)
//   s_valid (one-hot), s_ready, s_addr/s_wdata/s_wstrb (broadcast), s_rdata (flattened) : slave side
//   err_pulse/err_code/err_addr/err_count : error reporting (last error held, count saturates)
module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = {LED_BASE, UART_BASE, RAM_BASE, ROM_BASE},
    parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = {N_SLAVES{REGION_MASK}},
    parameter logic [N_SLAVES-1:0] RO_MASK = 4'b0001,
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_wstrb,
    output logic [31:0]            m_rdata,
    output logic [N_SLAVES-1:0]    s_valid,
    input  logic [N_SLAVES-1:0]    s_ready,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wstrb,
    input  logic [32*N_SLAVES-1:0] s_rdata,
    output logic                   err_pulse,
    output logic [1:0]             err_code,
    output logic [31:0]            err_addr,
    output logic [ERR_CNT_W-1:0]   err_count
);
    localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  m_ready_q, m_ready_d, err_pulse_q, err_pulse_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  hit, to_resp;
    logic [SW-1:0]         hit_sel;
    err_t                  err;

    mem_bus_addr_match #(
        .N_SLAVES  (N_SLAVES),
        .SW        (SW),
        .SLAVE_BASE(SLAVE_BASE),
        .SLAVE_MASK(SLAVE_MASK)
    ) u_match (
        .addr(m_addr),
        .hit (hit),
        .sel (hit_sel)
    );

    // Response-side registers are loaded on the transition into RESP so that
    // m_ready, m_rdata and the error outputs are all valid during RESP.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        m_ready_d   = 1'b0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        err_cnt_d   = err_cnt_q;
        to_resp     = 1'b0;
        err         = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    sel_d   = hit_sel;
                    if (!hit) begin
                        to_resp = 1'b1;
                        err     = ERR_UNMAPPED;
                    end else if (RO_MASK[hit_sel] && |m_wstrb) begin
                        to_resp = 1'b1;
                        err     = ERR_RO_WRITE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A ready arriving on the last allowed cycle beats the timeout.
                if (s_ready[sel_q]) begin
                    to_resp = 1'b1;
                    rdata_d = s_rdata[32*sel_q +: 32];
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == T_LAST) begin
                    to_resp = 1'b1;
                    err     = ERR_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_resp) begin
            state_d   = ST_RESP;
            cnt_d     = '0;
            m_ready_d = 1'b1;
            if (err != ERR_NONE) begin
                rdata_d     = DEFAULT_RDATA;
                err_pulse_d = 1'b1;
                err_code_d  = err;
                err_addr_d  = state_q == ST_IDLE ? m_addr : addr_q;
                err_cnt_d   = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            m_ready_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            m_ready_q   <= m_ready_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        s_valid        = '0;
        s_valid[sel_q] = state_q == ST_WAIT;
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = rdata_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb_mem_bus_fabric: directed self-checking bench for mem_bus_fabric
module tb_mem_bus_fabric;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [3:0]  s_valid, s_ready;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [127:0] s_rdata;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [1:0]  err_count;

    int checks = 0;
    int errors = 0;
    int dly [4];
    int wcnt [4];
    logic [3:0] extra_ready = 4'b0000;

    always #5 clk = ~clk;

    mem_bus_fabric #(
        .TIMEOUT_CYCLES(8),
        .ERR_CNT_W     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .err_pulse(err_pulse),
        .err_code (err_code),
        .err_addr (err_addr),
        .err_count(err_count)
    );

    assign s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5678};

    // Slave model: ready after dly[i] wait cycles of s_valid; extra_ready forces stray readies.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : slv
            always @(posedge clk) wcnt[g] <= s_valid[g] ? wcnt[g] + 1 : 0;
            assign s_ready[g] = (s_valid[g] && wcnt[g] >= dly[g]) || extra_ready[g];
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        output int lat, output int svc, output logic [3:0] svo);
        @(negedge clk);
        m_addr = a; m_wdata = wd; m_wstrb = ws; m_valid = 1'b1;
        lat = 1; svc = 0; svo = 4'b0;
        @(negedge clk);
        while (!m_ready && lat < 50) begin
            if (|s_valid) svc++;
            svo |= s_valid;
            @(negedge clk);
            lat++;
        end
        m_valid = 1'b0;
        if (lat >= 50) check("resp_bound", 32'd0, 32'd1);
    endtask

    int lat, svc;
    logic [3:0] svo;

    initial begin
        rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        dly = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("rst_m_ready", {31'b0, m_ready}, 32'd0);
        check("rst_s_valid", {28'b0, s_valid}, 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_err_count", {30'b0, err_count}, 32'd0);
        check("rst_err_code", {30'b0, err_code}, 32'd0);
        rst = 1'b0;

        xfer(32'h0000_0010, 32'h0, 4'b0000, lat, svc, svo);
        check("zw_lat", lat, 2);
        check("zw_sv_cycles", svc, 1);
        check("zw_sv_sel", {28'b0, svo}, 32'h1);
        check("zw_rdata", m_rdata, 32'h1234_5678);
        check("zw_err", {31'b0, err_pulse}, 32'd0);
        check("zw_s_addr", s_addr, 32'h0000_0010);
        check("resp_sv_low", {28'b0, s_valid}, 32'd0);

        dly[1] = 5; extra_ready = 4'b1101;
        xfer(32'h1000_0004, 32'hAABB_CCDD, 4'b0011, lat, svc, svo);
        extra_ready = 4'b0000;
        check("ws_lat", lat, 7);
        check("ws_sv_cycles", svc, 6);
        check("ws_sv_sel", {28'b0, svo}, 32'h2);
        check("ws_wstrb", {28'b0, s_wstrb}, 32'h3);
        check("ws_wdata", s_wdata, 32'hAABB_CCDD);
        check("ws_err", {31'b0, err_pulse}, 32'd0);

        xfer(32'h4000_0000, 32'h0, 4'b0000, lat, svc, svo);
        check("um_lat", lat, 1);
        check("um_sv", {28'b0, svo}, 32'd0);
        check("um_rdata", m_rdata, 32'd0);
        check("um_pulse", {31'b0, err_pulse}, 32'd1);
        check("um_code", {30'b0, err_code}, 32'd1);
        check("um_addr", err_addr, 32'h4000_0000);
        check("um_count", {30'b0, err_count}, 32'd1);

        xfer(32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, lat, svc, svo);
        check("ro_lat", lat, 1);
        check("ro_sv", {28'b0, svo}, 32'd0);
        check("ro_code", {30'b0, err_code}, 32'd3);
        check("ro_pulse", {31'b0, err_pulse}, 32'd1);
        check("ro_count", {30'b0, err_count}, 32'd2);
        xfer(32'h0000_0000, 32'h0, 4'b0000, lat, svc, svo);
        check("ro_rd_lat", lat, 2);
        check("ro_rd_data", m_rdata, 32'h1234_5678);
        check("ro_rd_err", {31'b0, err_pulse}, 32'd0);
        check("ro_code_hold", {30'b0, err_code}, 32'd3);

        dly[2] = 1000;
        xfer(32'h8000_0020, 32'h0, 4'b0000, lat, svc, svo);
        check("to_sv_cycles", svc, 8);
        check("to_lat", lat, 9);
        check("to_sv_sel", {28'b0, svo}, 32'h4);
        check("to_code", {30'b0, err_code}, 32'd2);
        check("to_rdata", m_rdata, 32'd0);
        check("to_addr", err_addr, 32'h8000_0020);
        check("to_count", {30'b0, err_count}, 32'd3);
        check("to_sv_low", {28'b0, s_valid}, 32'd0);

        dly[2] = 7;
        xfer(32'h8000_0000, 32'h0, 4'b0000, lat, svc, svo);
        check("edge_lat", lat, 9);
        check("edge_err", {31'b0, err_pulse}, 32'd0);
        check("edge_rdata", m_rdata, 32'h3333_3333);

        dly[1] = 1000;
        @(negedge clk);
        m_addr = 32'h1000_0000; m_wstrb = 4'b0000; m_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rw_sv_wait", {28'b0, s_valid}, 32'h2);
        rst = 1'b1; m_valid = 1'b0;
        @(negedge clk);
        check("rw_sv", {28'b0, s_valid}, 32'd0);
        check("rw_ready", {31'b0, m_ready}, 32'd0);
        check("rw_count", {30'b0, err_count}, 32'd0);
        rst = 1'b0;
        svc = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_ready || |s_valid) svc++;
        end
        check("rw_quiet", svc, 0);

        repeat (3) xfer(32'h4000_0000, 32'h0, 4'b0000, lat, svc, svo);
        check("sat_3", {30'b0, err_count}, 32'd3);
        repeat (2) xfer(32'h4000_0000, 32'h0, 4'b0000, lat, svc, svo);
        check("sat_5", {30'b0, err_count}, 32'd3);
        check("sat_pulse", {31'b0, err_pulse}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_fabric.md
Name: mem_bus_fabric

Overview:
Parametrised N-slave memory-bus interconnect for the picorv32 native memory interface, replacing the hard-coded ROM/RAM/UART/LED decode in the SoC top.
- Decodes each CPU request against per-slave base/mask regions and forwards it over a valid/ready handshake, so slaves may insert wait states.
- Returns read data to the CPU.
- Reports unmapped accesses, writes to read-only slaves and slave timeouts through an error side-channel.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
SLAVE_BASE, {32'h90000000,32'h80000000,32'h10000000,32'h00000000}, N_SLAVES x 32 flattened base addresses; slave i at bits [32i+31:32i]
SLAVE_MASK, {32'hFFFF0000 x4}, N_SLAVES x 32 flattened masks; hit_i = ((m_addr & MASK_i) == BASE_i)
RO_MASK, 4'b0001, bit i = 1 marks slave i read-only
TIMEOUT_CYCLES, 256, maximum wait cycles for s_ready; 0 disables the timeout
DEFAULT_RDATA, 32'h00000000, read data returned on any error
ERR_CNT_W, 8, width of the error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m_valid  in  1  CPU request valid
m_ready  out  1  CPU response strobe (registered, one-cycle pulse)
m_addr  in  32  CPU address
m_wdata  in  32  CPU write data
m_wstrb  in  4  CPU byte strobes; 0 = read
m_rdata  out  32  CPU read data (registered)
s_valid  out  N_SLAVES  one-hot request to the selected slave
s_ready  in  N_SLAVES  slave completion, one bit per slave
s_addr  out  32  latched address, broadcast to all slaves
s_wdata  out  32  latched write data, broadcast
s_wstrb  out  4  latched strobes, broadcast
s_rdata  in  N_SLAVES x 32  flattened slave read data
err_pulse  out  1  one cycle high, coincident with m_ready, on an errored transfer
err_code  out  2  0 none, 1 unmapped, 2 timeout, 3 read-only write; holds the last error
err_addr  out  32  address of the last errored transfer
err_count  out  ERR_CNT_W  saturating count of errors

Behaviour:
- Reset values: state IDLE; m_ready, err_pulse, s_valid, m_rdata, s_addr, s_wdata, s_wstrb, err_code, err_addr, err_count, timeout counter all 0.
- Reset mid-transfer aborts the transfer: no m_ready pulse and no slave handshake.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - When m_valid=1, latch addr/wdata/wstrb into s_addr/s_wdata/s_wstrb.
  - Decode by priority; the lowest-index hit wins on overlapping regions. Store the selected index.
  - Hit and not (RO slave and wstrb!=0): go to WAIT.
  - Miss: go to RESP with err=unmapped.
  - RO write: go to RESP with err=read-only write; the slave never sees s_valid.
- WAIT:
  - s_valid[sel]=1; all other s_valid bits are 0.
  - s_ready[sel]=1: capture s_rdata[sel] into m_rdata (for writes, m_rdata = captured value, don't-care to CPU); go to RESP.
  - s_ready bits of unselected slaves are ignored.
  - Otherwise increment the timeout counter. Counter == TIMEOUT_CYCLES-1 with no ready: drop s_valid, go to RESP with err=timeout.
  - s_ready arriving in the same cycle as the timeout wins, so no error is raised.
- RESP:
  - m_ready=1 for exactly one cycle; return to IDLE. Clear the timeout counter.
  - On error: m_rdata=DEFAULT_RDATA, err_pulse=1, err_code and err_addr updated, err_count incremented and saturating at all-ones.
- Latency from m_valid sampled in IDLE:
  - zero-wait slave: m_ready 2 cycles later;
  - k wait cycles: 2+k cycles;
  - miss or RO write: 1 cycle.
- Back-to-back requests: m_valid seen in the IDLE cycle after RESP starts a new transfer, so there are no idle bubbles beyond IDLE.
- m_valid deasserting during WAIT is a protocol violation. It is ignored and the transfer completes.
- Write strobes are passed through unchanged; byte-lane merging is the slave's job.

Decomposition:
- Package mem_bus_pkg holds:
  - state encoding (ST_IDLE, ST_WAIT, ST_RESP);
  - error codes (ERR_NONE=0, ERR_UNMAPPED=1, ERR_TIMEOUT=2, ERR_RO_WRITE=3);
  - the default ROM/RAM/UART/LED base and mask constants.
- One sub-module, mem_bus_addr_match: combinational per-slave base/mask compare plus a lowest-index priority encoder. Outputs hit and sel index.

Test Plan:
- Zero-wait read: addr 0x00000010, slave 0 returns 0x12345678 with s_ready tied high -> s_valid=4'b0001 for 1 cycle, m_ready 2 cycles after m_valid, m_rdata=0x12345678, err_pulse=0.
- Wait-state write: addr 0x10000004, wstrb 4'b0011, wdata 0xAABBCCDD, slave 1 ready after 5 cycles -> s_wstrb=0011, s_wdata=0xAABBCCDD, m_ready at cycle 7, no error.
- Unmapped read 0x40000000 -> no s_valid, m_ready after 1 cycle, m_rdata=0, err_code=1, err_addr=0x40000000, err_count=1.
- RO write: write 0x00000000 with wstrb 4'b1111 -> s_valid stays 0, m_ready after 1 cycle, err_code=3. A subsequent read of the same address succeeds.
- Timeout: TIMEOUT_CYCLES=8, slave 2 never ready -> s_valid[2] high exactly 8 cycles then low, m_ready, err_code=2, m_rdata=DEFAULT_RDATA.
- Reset/saturation: assert rst during WAIT -> no m_ready, s_valid=0 next cycle. With ERR_CNT_W=2, 5 unmapped accesses -> err_count=3.
